// File: rtl/hashcore_sched.sv
`default_nettype none
// ============================================================================
// hashcore_sched -- loads host work packets bit-serially into a hashcore bank
// and arbitrates golden-nonce strobes into one valid/ready result stream.
// Revision: 1.0
// ============================================================================
module hashcore_sched #(
  parameter int NUM_CORES  = 4,
  parameter int WORD_COUNT = 11
) (
  input  logic                    hash_clk,
  input  logic                    reset_n,
  input  logic [31:0]             wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    core_din,
  output logic                    core_shift,
  output logic [2*NUM_CORES-1:0]  core_nonce_msb,
  input  logic [29:0]             core_nonce0,
  input  logic [32*NUM_CORES-1:0] core_gn,
  input  logic [NUM_CORES-1:0]    core_gn_match,
  output logic [31:0]             gn_data,
  output logic [1:0]              gn_core,
  output logic                    gn_valid,
  input  logic                    gn_ready,
  output logic                    gn_overflow,
  output logic                    work_exhausted
);
  localparam int TOTAL_BITS = WORD_COUNT * 32;
  localparam int BIT_CNT_W  = $clog2(TOTAL_BITS + 1);
  localparam int WORD_CNT_W = $clog2(WORD_COUNT + 1);
  localparam logic [BIT_CNT_W-1:0]  C_LAST_CNT  = BIT_CNT_W'(TOTAL_BITS);
  localparam logic [BIT_CNT_W-1:0]  C_BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [WORD_CNT_W-1:0] C_LAST_WORD = WORD_CNT_W'(WORD_COUNT - 1);
  localparam logic [WORD_CNT_W-1:0] C_WORD_ONE  = WORD_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TOTAL_BITS-1:0]  stage_q, stage_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   shift_q, shift_d;
  logic                   din_q, din_d;
  logic [1:0]             post_q, post_d;
  logic [29:0]            nonce0_q;
  logic [NUM_CORES-1:0]   pend_q, pend_d;
  logic [31:0]            slot_q [NUM_CORES];
  logic [31:0]            slot_d [NUM_CORES];
  logic [1:0]             ptr_q, ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_data_q, out_data_d;
  logic [1:0]             out_core_q, out_core_d;
  logic                   ovf_q, ovf_d;
  logic                   exh_q, exh_d;
  logic                   accept, enter_shift, leave_shift, load, found;
  logic [1:0]             win, cand;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_nonce_msb
    assign core_nonce_msb[2*k +: 2] = 2'(k);
  end

  // The staging register doubles as the serialiser: words shift in at the
  // bottom, so word 0 ends up at the MSB and leaves first.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = 1'b0;
    din_d      = 1'b0;
    accept     = wr_valid & wr_ready_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          stage_d = (stage_q << 32) | TOTAL_BITS'(wr_data);
          if (word_cnt_q == C_LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = ST_SHIFT;
          end else begin
            word_cnt_d = word_cnt_q + C_WORD_ONE;
            state_d    = ST_FILL;
          end
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == C_LAST_CNT) begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          shift_d   = 1'b1;
          din_d     = stage_q[TOTAL_BITS-1];
          stage_d   = stage_q << 1;
          bit_cnt_d = bit_cnt_q + C_BIT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wr_ready_d  = (state_d != ST_SHIFT);
    enter_shift = (state_q != ST_SHIFT) && (state_d == ST_SHIFT);
    leave_shift = (state_q == ST_SHIFT) && (state_d != ST_SHIFT);
    post_d      = leave_shift ? 2'd2 : ((post_q != 2'd0) ? post_q - 2'd1 : 2'd0);
  end

  always_comb begin
    pend_d      = pend_q;
    slot_d      = slot_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_core_d  = out_core_q;
    ovf_d       = ovf_q;
    exh_d       = exh_q;
    found       = 1'b0;
    win         = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = 2'((int'(ptr_q) + i) % NUM_CORES);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    load = ~out_valid_q | gn_ready;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_data_d  = slot_q[win];
        out_core_d  = win;
        ptr_d       = win;
        pend_d[win] = 1'b0;
      end
    end
    // pend_d already reflects this cycle's take, so a take plus strobe is no overflow
    for (int k = 0; k < NUM_CORES; k++) begin
      if (core_gn_match[k]) begin
        if (shift_q) begin
          ovf_d = 1'b1;
        end else begin
          if (pend_d[k]) ovf_d = 1'b1;
          pend_d[k] = 1'b1;
          slot_d[k] = core_gn[k*32 +: 32];
        end
      end
    end
    if ((state_q != ST_SHIFT) && (post_q == 2'd0) &&
        (nonce0_q == 30'h3FFF_FFFF) && (core_nonce0 == 30'h0)) begin
      exh_d = 1'b1;
    end
    if (enter_shift) begin
      pend_d      = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
      exh_d       = 1'b0;
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      wr_ready_q  <= 1'b0;
      shift_q     <= 1'b0;
      din_q       <= 1'b0;
      post_q      <= 2'd0;
      nonce0_q    <= '0;
      pend_q      <= '0;
      for (int k = 0; k < NUM_CORES; k++) slot_q[k] <= '0;
      ptr_q       <= 2'(NUM_CORES - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_core_q  <= '0;
      ovf_q       <= 1'b0;
      exh_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      wr_ready_q  <= wr_ready_d;
      shift_q     <= shift_d;
      din_q       <= din_d;
      post_q      <= post_d;
      nonce0_q    <= core_nonce0;
      pend_q      <= pend_d;
      slot_q      <= slot_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_core_q  <= out_core_d;
      ovf_q       <= ovf_d;
      exh_q       <= exh_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign core_shift     = shift_q;
  assign core_din       = din_q;
  assign gn_valid       = out_valid_q;
  assign gn_data        = out_data_q;
  assign gn_core        = out_core_q;
  assign gn_overflow    = ovf_q;
  assign work_exhausted = exh_q;

endmodule
`default_nettype wire

// File: tb/tb_hashcore_sched.sv
`default_nettype none
// ============================================================================
// tb_hashcore_sched -- self-checking bench for hashcore_sched.
// Revision: 1.0
// ============================================================================
module tb_hashcore_sched;
  localparam int WORDS = 11;
  localparam int NBITS = WORDS * 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic         core_din;
  logic         core_shift;
  logic [7:0]   core_nonce_msb;
  logic [29:0]  core_nonce0;
  logic [127:0] core_gn;
  logic [3:0]   core_gn_match;
  logic [31:0]  gn_data;
  logic [1:0]   gn_core;
  logic         gn_valid;
  logic         gn_ready;
  logic         gn_overflow;
  logic         work_exhausted;

  hashcore_sched dut (
    .hash_clk(clk), .reset_n(reset_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .core_din(core_din), .core_shift(core_shift), .core_nonce_msb(core_nonce_msb),
    .core_nonce0(core_nonce0), .core_gn(core_gn), .core_gn_match(core_gn_match),
    .gn_data(gn_data), .gn_core(gn_core), .gn_valid(gn_valid), .gn_ready(gn_ready),
    .gn_overflow(gn_overflow), .work_exhausted(work_exhausted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] base;
    int          n;
    logic [7:0]  ord;   // expected grant order, entry j at [2j +: 2]
  } vec_t;

  typedef struct packed {
    logic [1:0]  core;
    logic [31:0] data;
  } res_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] pkt [WORDS];
  vec_t        vecs [6];
  res_t        sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_packet(input logic [31:0] base, input bit toggle);
    int w = 0;
    int cyc = 0;
    bit ph = 1'b0;
    while (w < WORDS && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ph = toggle ? ~ph : 1'b1;
      wr_valid = ph;
      wr_data  = base + 32'(w);
      if (ph && wr_ready) begin
        pkt[w] = base + 32'(w);
        w++;
      end
    end
    chk("pkt_accept_count", 64'(w), 64'(WORDS));
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  // Called just after the edge that accepted the last word.
  task automatic measure_shift(input string tag, input int strobe_at);
    int gaps = 0;
    int rdy_bad = 0;
    int bit_err = 0;
    logic [NBITS-1:0] got;
    logic [31:0] wv;
    @(negedge clk);
    chk({tag, "_shift_delay"}, 64'(core_shift), 64'd0);
    chk({tag, "_exh_cleared"}, 64'(work_exhausted), 64'd0);
    chk({tag, "_ovf_cleared"}, 64'(gn_overflow), 64'd0);
    chk({tag, "_valid_discard"}, 64'(gn_valid), 64'd0);
    for (int i = 0; i < NBITS; i++) begin
      @(negedge clk);
      core_gn_match = 4'b0000;
      if (!core_shift) gaps++;
      if (wr_ready) rdy_bad++;
      got[i] = core_din;
      wv = pkt[i / 32];
      if (core_din !== wv[31 - (i % 32)]) bit_err++;
      if (i == strobe_at) begin
        core_gn[31:0] = 32'h55;
        core_gn_match = 4'b0001;
      end
    end
    @(negedge clk);
    chk({tag, "_shift_end"}, 64'(core_shift), 64'd0);
    chk({tag, "_din_idle"}, 64'(core_din), 64'd0);
    chk({tag, "_ready_back"}, 64'(wr_ready), 64'd1);
    chk({tag, "_shift_gaps"}, 64'(gaps), 64'd0);
    chk({tag, "_ready_during_shift"}, 64'(rdy_bad), 64'd0);
    chk({tag, "_serial_bit_errors"}, 64'(bit_err), 64'd0);
    chk({tag, "_valid_after"}, 64'(gn_valid), 64'd0);
    if (tag == "p1") begin
      chk("p1_bit31", 64'(got[31]), 64'd1);
      chk("p1_bit351", 64'(got[351]), 64'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t exp_r;
    res_t act_r;
    logic [1:0] c;

    vecs[0] = '{4'b1111, 32'hA0,       4, 8'b11_10_01_00};
    vecs[1] = '{4'b0101, 32'h1000,     2, 8'b00_00_10_00};
    vecs[2] = '{4'b1011, 32'h2000,     3, 8'b00_01_00_11};
    vecs[3] = '{4'b0100, 32'h3000,     1, 8'b00_00_00_10};
    vecs[4] = '{4'b1001, 32'h4000,     2, 8'b00_00_00_11};
    vecs[5] = '{4'b0001, 32'hDEAD0000, 1, 8'b00_00_00_00};

    reset_n = 1'b0; wr_data = '0; wr_valid = 1'b0; core_nonce0 = '0;
    core_gn = '0; core_gn_match = '0; gn_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_shift", 64'(core_shift), 64'd0);
    chk("rst_din", 64'(core_din), 64'd0);
    chk("rst_gn_valid", 64'(gn_valid), 64'd0);
    chk("rst_gn_data", 64'(gn_data), 64'd0);
    chk("rst_gn_core", 64'(gn_core), 64'd0);
    chk("rst_ovf", 64'(gn_overflow), 64'd0);
    chk("rst_exh", 64'(work_exhausted), 64'd0);
    chk("nonce_msb", 64'(core_nonce_msb), 64'hE4);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(wr_ready), 64'd1);

    // Packet 1: words 1..11, wr_valid held high
    send_packet(32'h1, 1'b0);
    measure_shift("p1", -1);

    // Arbiter vectors with scoreboard
    gn_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) core_gn[32*k +: 32] = vecs[v].base + 32'(k);
      core_gn_match = vecs[v].mask;
      for (int j = 0; j < vecs[v].n; j++) begin
        c = vecs[v].ord[2*j +: 2];
        sb.push_back('{c, vecs[v].base + 32'(c)});
      end
      @(negedge clk);
      core_gn_match = 4'b0000;
      chk("arb_latency", 64'(gn_valid), 64'd0);
      for (int j = 0; j < vecs[v].n; j++) begin
        @(negedge clk);
        exp_r = sb.pop_front();
        act_r = '{gn_core, gn_data};
        chk("arb_valid", 64'(gn_valid), 64'd1);
        chk("arb_result", 64'(act_r), 64'(exp_r));
      end
      @(negedge clk);
      chk("arb_drain", 64'(gn_valid), 64'd0);
    end
    chk("arb_sb_empty", 64'(sb.size()), 64'd0);
    chk("arb_no_ovf", 64'(gn_overflow), 64'd0);

    // Backpressure and overwrite on core 2
    gn_ready = 1'b0;
    core_gn[95:64] = 32'h10; core_gn_match = 4'b0100;
    @(negedge clk); core_gn_match = 4'b0000;
    @(negedge clk);
    chk("bp_first", 64'({gn_valid, gn_core, gn_data}), {29'd0, 1'b1, 2'd2, 32'h10});
    core_gn[95:64] = 32'h20; core_gn_match = 4'b0100;
    @(negedge clk); core_gn_match = 4'b0000;
    chk("bp_hold", 64'(gn_data), 64'h10);
    gn_ready = 1'b1;
    @(negedge clk); gn_ready = 1'b0;
    chk("bp_second", 64'({gn_valid, gn_data}), {31'd0, 1'b1, 32'h20});
    chk("bp_no_ovf", 64'(gn_overflow), 64'd0);
    core_gn[95:64] = 32'h30; core_gn_match = 4'b0100;
    @(negedge clk); core_gn_match = 4'b0000;
    chk("bp_ovf_pre", 64'(gn_overflow), 64'd0);
    core_gn[95:64] = 32'h40; core_gn_match = 4'b0100;
    @(negedge clk); core_gn_match = 4'b0000;
    chk("bp_ovf_set", 64'(gn_overflow), 64'd1);
    chk("bp_stable", 64'(gn_data), 64'h20);
    gn_ready = 1'b1;
    @(negedge clk);
    chk("bp_overwritten", 64'({gn_valid, gn_data}), {31'd0, 1'b1, 32'h40});
    @(negedge clk);
    chk("bp_drained", 64'(gn_valid), 64'd0);
    chk("bp_ovf_sticky", 64'(gn_overflow), 64'd1);

    // Exhaustion outside SHIFT
    core_nonce0 = 30'h3FFF_FFFE;
    @(negedge clk); core_nonce0 = 30'h3FFF_FFFF;
    @(negedge clk);
    chk("exh_not_yet", 64'(work_exhausted), 64'd0);
    core_nonce0 = 30'h0;
    @(negedge clk);
    chk("exh_set", 64'(work_exhausted), 64'd1);

    // Results left pending before a new packet must be discarded
    gn_ready = 1'b0;
    core_gn[63:32] = 32'h77; core_gn[127:96] = 32'h88; core_gn_match = 4'b1010;
    @(negedge clk); core_gn_match = 4'b0000;
    @(negedge clk);
    chk("rr_after_core2", 64'({gn_valid, gn_core, gn_data}), {29'd0, 1'b1, 2'd3, 32'h88});

    // Packet 2: toggling wr_valid, strobe dropped mid-shift
    send_packet(32'hCAFE_0000, 1'b1);
    measure_shift("p2", 50);
    chk("p2_drop_ovf", 64'(gn_overflow), 64'd1);
    gn_ready = 1'b1;
    core_nonce0 = 30'h3FFF_FFFF;
    @(negedge clk); core_nonce0 = 30'h0;
    @(negedge clk);
    chk("post_window_valid", 64'(gn_valid), 64'd0);
    chk("post_window_exh", 64'(work_exhausted), 64'd0);
    @(negedge clk);
    chk("post_window_exh2", 64'(work_exhausted), 64'd0);
    core_nonce0 = 30'h3FFF_FFFF;
    @(negedge clk); core_nonce0 = 30'h0;
    @(negedge clk);
    chk("exh_after_window", 64'(work_exhausted), 64'd1);

    // Packet 3 aborted by reset at shift bit 100
    send_packet(32'h5A5A_0000, 1'b0);
    @(negedge clk);
    repeat (101) @(negedge clk);
    chk("p3_shifting", 64'(core_shift), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_shift", 64'(core_shift), 64'd0);
    chk("rst_async_ready", 64'(wr_ready), 64'd0);
    chk("rst_async_outs", 64'({core_din, gn_valid, gn_overflow, work_exhausted, gn_core, gn_data}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Packet 4 after reset
    send_packet(32'h8000_0001, 1'b0);
    measure_shift("p4", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
